ecp5pll_phase_sweep: RTL and testbench

Automatic SDRAM clock-phase calibrator for the memory-test top level. It drives the ECP5 PLL dynamic phase port (phasedir/phasestep/phaseloadreg), steps the chip clock through every phase position, and runs the memory tester for a fixed dwell at each position. It then finds the widest circular passing window and parks the phase at its centre. It is the parametrised successor to the button-only phase stepper, which it also replaces for manual fine-tuning.

---
 rtl/ecp5pll_phase_pkg.sv | 22 ++
 rtl/pll_phase_stepper.sv | 64 ++++++
 rtl/ecp5pll_phase_sweep.sv | 194 +++++++++++++++++++
 tb/tb_ecp5pll_phase_sweep.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecp5pll_phase_pkg.sv
// Shared types for the ECP5 PLL phase sweep: controller states and step directions.
package ecp5pll_phase_pkg;

    // state | meaning: IDLE wait | SETUP/PULSE/GAP one PLL step | SETTLE tester in reset
    // DWELL tester runs | EVAL issue next step | SEARCH window scan | CENTER park | DONE report
    typedef enum logic [3:0] {
        ST_IDLE, ST_SETUP, ST_PULSE, ST_GAP, ST_SETTLE,
        ST_DWELL, ST_EVAL, ST_SEARCH, ST_CENTER, ST_DONE
    } sweep_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pll_phase_stepper.sv
// One ECP5 dynamic-phase step: SETUP latches direction, PULSE drives phasestep, GAP rests.
module pll_phase_stepper
    import ecp5pll_phase_pkg::*;
#(
    parameter int C_pulse = 4,
    parameter int C_gap   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic dir,
    output logic phasedir,
    output logic phasestep,
    output logic ack,
    output logic setup,
    output logic idle
);
    localparam int CW = $clog2(max3(C_pulse, C_gap, 2)) + 1;

    sweep_state_t st;
    logic [CW-1:0] cnt;

    assign ack   = (st == ST_GAP) && (cnt == '0);
    assign setup = (st == ST_SETUP);
    assign idle  = (st == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            phasedir  <= DIR_FWD;
            phasestep <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (req) begin
                        phasedir <= dir;
                        st       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    phasestep <= 1'b1;
                    cnt       <= CW'(C_pulse - 1);
                    st        <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        phasestep <= 1'b0;
                        cnt       <= CW'(C_gap - 1);
                        st        <= ST_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) st <= ST_IDLE;
                    else           cnt <= cnt - 1'b1;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ecp5pll_phase_sweep.sv
// SDRAM clock-phase calibrator: sweeps every PLL phase, finds the widest passing window, parks at its centre.
// Define PHASE_SWEEP_MANUAL_EN to add inc/dec manual single-step ports.
module ecp5pll_phase_sweep
    import ecp5pll_phase_pkg::*;
#(
    parameter int C_steps      = 32,
    parameter int C_phase_bits = 8,
    parameter int C_pulse      = 4,
    parameter int C_gap        = 4,
    parameter int C_settle     = 256,
    parameter int C_dwell      = 1 << 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
`ifdef PHASE_SWEEP_MANUAL_EN
    input  logic                    inc,
    input  logic                    dec,
`endif
    input  logic [31:0]             passcount,
    input  logic [31:0]             failcount,
    output logic                    phasedir,
    output logic                    phasestep,
    output logic                    phaseloadreg,
    output logic                    memtest_rst,
    output logic [C_phase_bits-1:0] phase,
    output logic [C_phase_bits-1:0] win_start,
    output logic [C_phase_bits-1:0] win_len,
    output logic                    busy,
    output logic                    done,
    output logic                    fail
);
    localparam int PB = C_phase_bits;
    localparam int WB = C_phase_bits + 2;
    localparam int CW = $clog2(max3(C_settle, C_dwell, 2 * C_steps)) + 1;

    sweep_state_t     st;
    logic [CW-1:0]    cnt;
    logic [PB-1:0]    pos, idx, run, moved;
    logic [C_steps-1:0] pass_map;

    logic             req_c, dir_c, stp_ack, stp_setup, stp_idle, pass_now, pass_bit;
    logic [PB-1:0]    run_n, start_c, target_c, phase_next;
    logic [WB-1:0]    sum_w, tgt_w;

    assign phaseloadreg = 1'b0;
    assign pass_now     = (passcount != '0) && (failcount == '0);

    pll_phase_stepper #(.C_pulse(C_pulse), .C_gap(C_gap)) u_stepper (
        .clk(clk), .rst(rst), .req(req_c), .dir(dir_c),
        .phasedir(phasedir), .phasestep(phasestep),
        .ack(stp_ack), .setup(stp_setup), .idle(stp_idle)
    );

    always_comb begin
        req_c = 1'b0;
        dir_c = DIR_FWD;
        case (st)
            ST_EVAL:   req_c = 1'b1;
            ST_CENTER: req_c = stp_idle && (moved != target_c);
`ifdef PHASE_SWEEP_MANUAL_EN
            ST_IDLE: begin
                if (!start && (inc ^ dec)) begin
                    req_c = 1'b1;
                    dir_c = dec ? DIR_BWD : DIR_FWD;
                end
            end
`endif
            default: ;
        endcase
    end

    // Window scan runs twice round the bitmap so a window crossing C_steps-1 -> 0 is seen whole.
    always_comb begin
        pass_bit = 1'b0;
        for (int k = 0; k < C_steps; k++)
            if (idx == PB'(k)) pass_bit = pass_map[k];
        run_n = '0;
        if (pass_bit) run_n = (run == PB'(C_steps)) ? run : run + 1'b1;
        sum_w = WB'(idx) + WB'(C_steps) + WB'(1) - WB'(run_n);
        if (sum_w >= WB'(C_steps)) sum_w = sum_w - WB'(C_steps);
        start_c = PB'(sum_w);
        tgt_w = WB'(win_start) + WB'(win_len >> 1);
        if (tgt_w >= WB'(C_steps)) tgt_w = tgt_w - WB'(C_steps);
        target_c = (win_len == '0 || win_len == PB'(C_steps)) ? '0 : PB'(tgt_w);
        if (phasedir == DIR_BWD) phase_next = (phase == '0) ? PB'(C_steps - 1) : phase - 1'b1;
        else                     phase_next = (phase == PB'(C_steps - 1)) ? '0 : phase + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= ST_IDLE;
            cnt         <= '0;
            pos         <= '0;
            idx         <= '0;
            run         <= '0;
            moved       <= '0;
            pass_map    <= '0;
            memtest_rst <= 1'b1;
            phase       <= '0;
            win_start   <= '0;
            win_len     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            if (stp_setup) phase <= phase_next;
            case (st)
                ST_IDLE: begin
                    memtest_rst <= 1'b0;
                    if (start) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        fail        <= 1'b0;
                        memtest_rst <= 1'b1;
                        pos         <= '0;
                        cnt         <= CW'(C_settle - 1);
                        st          <= ST_SETTLE;
                    end else if (req_c) begin
                        st <= ST_SETUP;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        memtest_rst <= 1'b0;
                        cnt         <= CW'(C_dwell - 1);
                        st          <= ST_DWELL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (cnt == '0) begin
                        for (int k = 0; k < C_steps; k++)
                            if (pos == PB'(k)) pass_map[k] <= pass_now;
                        st <= ST_EVAL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_EVAL: begin
                    memtest_rst <= 1'b1;
                    st          <= ST_SETUP;
                end
                // busy distinguishes a sweep step from a manual one
                ST_SETUP: begin
                    if (stp_ack) begin
                        if (!busy) begin
                            st <= ST_IDLE;
                        end else if (pos == PB'(C_steps - 1)) begin
                            memtest_rst <= 1'b0;
                            win_start   <= '0;
                            win_len     <= '0;
                            run         <= '0;
                            idx         <= '0;
                            cnt         <= CW'(2 * C_steps - 1);
                            st          <= ST_SEARCH;
                        end else begin
                            pos <= pos + 1'b1;
                            cnt <= CW'(C_settle - 1);
                            st  <= ST_SETTLE;
                        end
                    end
                end
                ST_SEARCH: begin
                    run <= run_n;
                    if (run_n > win_len) begin
                        win_len   <= run_n;
                        win_start <= start_c;
                    end
                    idx <= (idx == PB'(C_steps - 1)) ? '0 : idx + 1'b1;
                    if (cnt == '0) begin
                        moved <= '0;
                        st    <= ST_CENTER;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CENTER: begin
                    if (stp_setup) moved <= moved + 1'b1;
                    if (stp_idle && moved == target_c) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        fail <= (win_len == '0);
                        st   <= ST_DONE;
                    end
                end
                ST_DONE: st <= ST_IDLE;
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecp5pll_phase_sweep.sv
// Bench for ecp5pll_phase_sweep: PLL and mem_tester models, window reference model, done-triggered scoreboard.
module tb_ecp5pll_phase_sweep;
    import ecp5pll_phase_pkg::*;

    localparam int C_STEPS = 8;
    localparam int PB = 8;
    localparam int C_PULSE = 2;
    localparam int C_GAP = 3;
    localparam int C_SETTLE = 4;
    localparam int C_DWELL = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
`ifdef PHASE_SWEEP_MANUAL_EN
    logic inc = 1'b0;
    logic dec = 1'b0;
`endif
    logic [31:0] passcount, failcount;
    logic phasedir, phasestep, phaseloadreg, memtest_rst, busy, done, fail;
    logic [PB-1:0] phase, win_start, win_len;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecp5pll_phase_sweep #(
        .C_steps(C_STEPS), .C_phase_bits(PB), .C_pulse(C_PULSE),
        .C_gap(C_GAP), .C_settle(C_SETTLE), .C_dwell(C_DWELL)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef PHASE_SWEEP_MANUAL_EN
        .inc(inc), .dec(dec),
`endif
        .passcount(passcount), .failcount(failcount),
        .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
        .memtest_rst(memtest_rst), .phase(phase), .win_start(win_start),
        .win_len(win_len), .busy(busy), .done(done), .fail(fail)
    );

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    // Physical PLL and memory tester. Pattern is indexed relative to the phase at sweep start.
    int phys = 0;
    int origin = 0;
    int pulse_cnt = 0;
    int tmode = 0;
    logic [C_STEPS-1:0] pattern = '0;
    logic ps_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phys <= 0;
            ps_q <= 1'b0;
            passcount <= '0;
            failcount <= '0;
        end else begin
            ps_q <= phasestep;
            if (phasestep && !ps_q) begin
                phys <= (phasedir == DIR_BWD) ? (phys + C_STEPS - 1) % C_STEPS : (phys + 1) % C_STEPS;
                pulse_cnt <= pulse_cnt + 1;
            end
            if (memtest_rst) begin
                passcount <= '0;
                failcount <= '0;
            end else if (pattern[(phys - origin + C_STEPS) % C_STEPS]) begin
                passcount <= passcount + 1;
            end else if (tmode == 0) begin
                passcount <= passcount + 1;
                failcount <= 32'd1;
            end
        end
    end

    // Longest circular run of passing positions; on ties the run completed first in a 2-lap scan wins.
    task automatic ref_model(input logic [C_STEPS-1:0] pat, output int ws, output int wl, output int tg);
        bit ok;
        ws = 0;
        wl = 0;
        for (int len = C_STEPS; len >= 1 && wl == 0; len--)
            for (int i = len - 1; i < 2 * C_STEPS && wl == 0; i++) begin
                ok = 1'b1;
                for (int k = 0; k < len; k++)
                    if (!pat[(i - k) % C_STEPS]) ok = 1'b0;
                if (ok) begin
                    wl = len;
                    ws = (i - len + 1) % C_STEPS;
                end
            end
        tg = (wl == 0 || wl == C_STEPS) ? 0 : (ws + wl / 2) % C_STEPS;
    endtask

    typedef struct {
        int ws;
        int wl;
        int ph;
        int fl;
        int npulse;
        int base;
    } exp_t;
    exp_t exp_q[$];

    logic done_q = 1'b0;
    int hi_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hi_cnt = 0;
            done_q = 1'b0;
        end else begin
            if (phasestep) begin
                hi_cnt++;
            end else if (hi_cnt != 0) begin
                chk("pulse_width", hi_cnt, C_PULSE);
                hi_cnt = 0;
            end
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("win_start", int'(win_start), e.ws);
                    chk("win_len", int'(win_len), e.wl);
                    chk("final_phase", int'(phase), e.ph);
                    chk("fail", int'(fail), e.fl);
                    chk("pulses", pulse_cnt - e.base, e.npulse);
                    chk("busy_at_done", int'(busy), 0);
                    chk("mrst_at_done", int'(memtest_rst), 0);
                end
            end
            done_q = done;
        end
    end

    task automatic reset_chk(input string tag);
        chk({tag, "_vector"},
            int'({phasestep, phasedir, phaseloadreg, memtest_rst, busy, done, fail}), 7'b0001000);
        chk({tag, "_phase"}, int'(phase), 0);
        chk({tag, "_win_start"}, int'(win_start), 0);
        chk({tag, "_win_len"}, int'(win_len), 0);
    endtask

    task automatic run_sweep(input logic [C_STEPS-1:0] pat, input int mode, input bit poke);
        exp_t e;
        int ws, wl, tg, n;
        ref_model(pat, ws, wl, tg);
        pattern = pat;
        tmode = mode;
        origin = phys;
        e.ws = ws;
        e.wl = wl;
        e.ph = (phys + tg) % C_STEPS;
        e.fl = (wl == 0) ? 1 : 0;
        e.npulse = C_STEPS + tg;
        e.base = pulse_cnt;
        exp_q.push_back(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_rise", int'(busy), 1);
        if (poke) begin
            repeat (30) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(done), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic mid_reset();
        int base, n;
        pattern = 8'($urandom);
        tmode = 0;
        origin = phys;
        base = pulse_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(pulse_cnt - base == 4 && !memtest_rst) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_pos4_dwell", pulse_cnt - base, 4);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 reset_chk("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mrst_fall", int'(memtest_rst), 0);
    endtask

`ifdef PHASE_SWEEP_MANUAL_EN
    task automatic manual_step(input bit up, input bit both);
        int base, want, n;
        base = pulse_cnt;
        want = both ? phys : (up ? (phys + 1) % C_STEPS : (phys + C_STEPS - 1) % C_STEPS);
        @(negedge clk);
        inc = up | both;
        dec = !up | both;
        @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
        if (!both) begin
            n = 0;
            while (!phasestep && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("man_pulse_seen", int'(phasestep), 1);
            chk("man_dir", int'(phasedir), up ? int'(DIR_FWD) : int'(DIR_BWD));
        end
        repeat (C_PULSE + C_GAP + 4) @(negedge clk);
        chk("man_phase", int'(phase), want);
        chk("man_pulses", pulse_cnt - base, both ? 0 : 1);
        chk("man_no_mrst", int'(memtest_rst), 0);
    endtask
`endif

    initial begin
        #1 rst = 1'b1;
        #1 reset_chk("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("mrst_hold", int'(memtest_rst), 1);
        @(negedge clk);
        chk("mrst_fall", int'(memtest_rst), 0);

        run_sweep(8'b0001_1100, 0, 1'b0);
        run_sweep(8'b1000_0011, 0, 1'b1);
        run_sweep(8'b0000_0000, 0, 1'b0);
        run_sweep(8'b0000_0000, 1, 1'b0);
        run_sweep(8'b1111_1111, 0, 1'b0);
        run_sweep(8'b0010_0010, 1, 1'b0);
        for (int i = 0; i < 6; i++)
            run_sweep(8'($urandom), int'($urandom_range(0, 1)), i == 2);
        run_sweep(8'b0111_0000, 0, 1'b0);
        mid_reset();
        run_sweep(8'($urandom), 0, 1'b0);
`ifdef PHASE_SWEEP_MANUAL_EN
        manual_step(1'b0, 1'b0);
        manual_step(1'b1, 1'b0);
        manual_step(1'b1, 1'b0);
        manual_step(1'b0, 1'b1);
`endif
        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
